// File: rtl/aln_stats_collector.sv
`default_nettype none
// ============================================================================
// Module      : aln_stats_collector
// Description : Consumes one aligned reference/query word pair from the banded
//               Smith-Waterman accelerator and reduces it to one statistics
//               record. The record holds the match, mismatch and gap counts,
//               a saturating linear-gap score and an illegal-column flag. The
//               record is offered on a valid/ready handshake.
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   reset        : asynchronous, active-high; clears all state
//   aln_ready    : accelerator ready level; a rising level starts a capture
//   R_aligned    : aligned reference, column 0 in the top 3 bits
//   Q_aligned    : aligned query, same packing as R_aligned
//   out_valid    : result record valid
//   out_ready    : downstream accepts the record
//   match_cnt    : number of matching columns
//   mismatch_cnt : number of mismatching columns
//   gap_cnt      : number of columns with a gap on exactly one side
//   score        : signed saturating alignment score
//   invalid      : the record contained at least one illegal column
//   overflow     : sticky; an alignment arrived while busy and was dropped
//   busy         : high while scanning or while holding a record
//
// Revision    : 1.0  initial release
// ============================================================================
module aln_stats_collector #(
  parameter int NSYM     = 10,
  parameter int MATCH    = 2,
  parameter int MISMATCH = 1,
  parameter int GAP      = 2,
  parameter int SCORE_W  = 8,
  parameter int CNT_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      aln_ready,
  input  logic [NSYM*3-1:0]         R_aligned,
  input  logic [NSYM*3-1:0]         Q_aligned,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          match_cnt,
  output logic [CNT_W-1:0]          mismatch_cnt,
  output logic [CNT_W-1:0]          gap_cnt,
  output logic signed [SCORE_W-1:0] score,
  output logic                      invalid,
  output logic                      overflow,
  output logic                      busy
);

  localparam int                      c_WW    = NSYM * 3;
  localparam logic [CNT_W-1:0]        c_LAST  = CNT_W'(NSYM - 1);
  localparam logic [CNT_W-1:0]        c_ONE   = CNT_W'(1);
  localparam logic [2:0]              c_GAP   = 3'b100;
  localparam logic [2:0]              c_PAD   = 3'b111;
  localparam logic signed [SCORE_W:0] c_D_MAT = (SCORE_W+1)'(MATCH);
  localparam logic signed [SCORE_W:0] c_D_MIS = (SCORE_W+1)'(-MISMATCH);
  localparam logic signed [SCORE_W:0] c_D_GAP = (SCORE_W+1)'(-GAP);
  localparam logic signed [SCORE_W:0] c_S_MAX = (SCORE_W+1)'((1 << (SCORE_W-1)) - 1);
  localparam logic signed [SCORE_W:0] c_S_MIN = (SCORE_W+1)'(-(1 << (SCORE_W-1)));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_ready_q;
  logic [c_WW-1:0]             r_r_sh;
  logic [c_WW-1:0]             r_q_sh;
  logic [CNT_W-1:0]            r_idx;
  logic [CNT_W-1:0]            r_match;
  logic [CNT_W-1:0]            r_mismatch;
  logic [CNT_W-1:0]            r_gap;
  logic signed [SCORE_W-1:0]   r_score;
  logic                        r_invalid;
  logic                        r_out_valid;
  logic                        r_overflow;

  logic                        w_rise;
  logic                        w_accept;
  logic                        w_capture;
  logic                        w_drop;
  logic                        w_last;
  logic [2:0]                  w_col_r;
  logic [2:0]                  w_col_q;
  logic                        w_r_base;
  logic                        w_q_base;
  logic                        w_is_match;
  logic                        w_is_mis;
  logic                        w_is_gap;
  logic                        w_is_pad;
  logic                        w_is_bad;
  logic signed [SCORE_W:0]     w_delta;
  logic signed [SCORE_W:0]     w_score_ext;
  logic signed [SCORE_W-1:0]   w_score_sat;

  // --------------------------------------------------------------------------
  // Handshake / control decode
  // --------------------------------------------------------------------------
  assign w_rise    = aln_ready & ~r_ready_q;
  assign w_accept  = (r_state == S_DONE) & r_out_valid & out_ready;
  // A rise is taken when idle, or when it lands on the edge that frees the
  // record; any other rise is lost and flagged.
  assign w_capture = w_rise & ((r_state == S_IDLE) | w_accept);
  assign w_drop    = w_rise & ~w_capture;
  assign w_last    = (r_idx == c_LAST);

  // --------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_capture) w_state_nxt = S_SCAN;
      S_SCAN: if (w_last)    w_state_nxt = S_DONE;
      S_DONE: if (w_accept)  w_state_nxt = w_capture ? S_SCAN : S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Column classification (current column sits in the top 3 bits)
  // --------------------------------------------------------------------------
  assign w_col_r    = r_r_sh[c_WW-1 -: 3];
  assign w_col_q    = r_q_sh[c_WW-1 -: 3];
  assign w_r_base   = ~w_col_r[2];
  assign w_q_base   = ~w_col_q[2];
  assign w_is_match = w_r_base & w_q_base & (w_col_r == w_col_q);
  assign w_is_mis   = w_r_base & w_q_base & (w_col_r != w_col_q);
  assign w_is_gap   = (w_r_base & (w_col_q == c_GAP)) | (w_q_base & (w_col_r == c_GAP));
  assign w_is_pad   = (w_col_r == c_PAD) & (w_col_q == c_PAD);
  assign w_is_bad   = ~(w_is_match | w_is_mis | w_is_gap | w_is_pad);

  always_comb begin
    w_delta = '0;
    if (w_is_match)    w_delta = c_D_MAT;
    else if (w_is_mis) w_delta = c_D_MIS;
    else if (w_is_gap) w_delta = c_D_GAP;
  end

  // One guard bit is enough to detect a single step leaving the score range.
  assign w_score_ext = $signed({r_score[SCORE_W-1], r_score}) + w_delta;

  always_comb begin
    w_score_sat = w_score_ext[SCORE_W-1:0];
    if (w_score_ext > c_S_MAX)      w_score_sat = c_S_MAX[SCORE_W-1:0];
    else if (w_score_ext < c_S_MIN) w_score_sat = c_S_MIN[SCORE_W-1:0];
  end

  // --------------------------------------------------------------------------
  // Datapath and record registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready_q   <= 1'b0;
      r_r_sh      <= '0;
      r_q_sh      <= '0;
      r_idx       <= '0;
      r_match     <= '0;
      r_mismatch  <= '0;
      r_gap       <= '0;
      r_score     <= '0;
      r_invalid   <= 1'b0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_ready_q <= aln_ready;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_capture) begin
        r_r_sh      <= R_aligned;
        r_q_sh      <= Q_aligned;
        r_idx       <= '0;
        r_match     <= '0;
        r_mismatch  <= '0;
        r_gap       <= '0;
        r_score     <= '0;
        r_invalid   <= 1'b0;
        r_out_valid <= 1'b0;
      end else if (r_state == S_SCAN) begin
        // Shift pad in behind; the filler is never examined.
        r_r_sh <= {r_r_sh[c_WW-4:0], c_PAD};
        r_q_sh <= {r_q_sh[c_WW-4:0], c_PAD};
        r_idx  <= r_idx + c_ONE;
        if (w_is_match) r_match    <= r_match + c_ONE;
        if (w_is_mis)   r_mismatch <= r_mismatch + c_ONE;
        if (w_is_gap)   r_gap      <= r_gap + c_ONE;
        if (w_is_bad)   r_invalid  <= 1'b1;
        r_score <= w_score_sat;
        if (w_last) begin
          r_out_valid <= 1'b1;
        end
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign match_cnt    = r_match;
  assign mismatch_cnt = r_mismatch;
  assign gap_cnt      = r_gap;
  assign score        = r_score;
  assign invalid      = r_invalid;
  assign overflow     = r_overflow;
  assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aln_stats_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_aln_stats_collector
// Description : Self-checking bench for aln_stats_collector. Two instances
//               share stimulus: the default 8-bit score and a 4-bit score that
//               exercises saturation. A column-level behavioural model gives
//               the expected record; literal values pin the model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aln_stats_collector;

  typedef struct {
    int m;
    int mm;
    int g;
    int sc;
    int inv;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        aln_ready;
  logic        out_ready;
  logic [29:0] R;
  logic [29:0] Q;

  logic              vA, iA, oA, bA;
  logic [3:0]        mA, mmA, gA;
  logic signed [7:0] sA;
  logic              vB, iB, oB, bB;
  logic [3:0]        mB, mmB, gB;
  logic signed [3:0] sB;

  rec_t expA, expB;
  int   exp_ovf = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  aln_stats_collector uA (
    .clk(clk), .reset(reset), .aln_ready(aln_ready),
    .R_aligned(R), .Q_aligned(Q),
    .out_valid(vA), .out_ready(out_ready),
    .match_cnt(mA), .mismatch_cnt(mmA), .gap_cnt(gA),
    .score(sA), .invalid(iA), .overflow(oA), .busy(bA)
  );

  aln_stats_collector #(.SCORE_W(4)) uB (
    .clk(clk), .reset(reset), .aln_ready(aln_ready),
    .R_aligned(R), .Q_aligned(Q),
    .out_valid(vB), .out_ready(out_ready),
    .match_cnt(mB), .mismatch_cnt(mmB), .gap_cnt(gB),
    .score(sB), .invalid(iB), .overflow(oB), .busy(bB)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // A C G T, '-' gap, '.' pad, 'x' illegal code 101
  function automatic logic [29:0] enc(input string s);
    logic [29:0] w;
    w = '0;
    for (int i = 0; i < 10; i++) begin
      logic [2:0] c;
      case (s[i])
        "A":     c = 3'd0;
        "C":     c = 3'd1;
        "G":     c = 3'd2;
        "T":     c = 3'd3;
        "-":     c = 3'd4;
        "x":     c = 3'd5;
        default: c = 3'd7;
      endcase
      w[29-3*i -: 3] = c;
    end
    return w;
  endfunction

  function automatic rec_t model(input logic [29:0] r, input logic [29:0] q, input int sw);
    rec_t t;
    int   hi;
    int   lo;
    t  = '{default: 0};
    hi = (1 << (sw - 1)) - 1;
    lo = -(1 << (sw - 1));
    for (int i = 0; i < 10; i++) begin
      int a;
      int b;
      a = int'(r[29-3*i -: 3]);
      b = int'(q[29-3*i -: 3]);
      if (a < 4 && b < 4) begin
        if (a == b) begin t.m++;  t.sc += 2; end
        else        begin t.mm++; t.sc -= 1; end
      end else if ((a < 4 && b == 4) || (b < 4 && a == 4)) begin
        t.g++; t.sc -= 2;
      end else if (!(a == 7 && b == 7)) begin
        t.inv = 1;
      end
      if (t.sc > hi) t.sc = hi;
      if (t.sc < lo) t.sc = lo;
    end
    return t;
  endfunction

  // Continuous record check whenever a record is being offered.
  always @(negedge clk) begin
    if (!reset) begin
      if (vA) begin
        chk("recA_match", int'(mA), expA.m);
        chk("recA_mism",  int'(mmA), expA.mm);
        chk("recA_gap",   int'(gA), expA.g);
        chk("recA_score", int'(sA), expA.sc);
        chk("recA_inv",   int'(iA), expA.inv);
        chk("recA_ovf",   int'(oA), exp_ovf);
        chk("recA_busy",  int'(bA), 1);
      end
      if (vB) begin
        chk("recB_score", int'(sB), expB.sc);
        chk("recB_match", int'(mB), expB.m);
        chk("recB_inv",   int'(iB), expB.inv);
        chk("recB_ovf",   int'(oB), exp_ovf);
      end
    end
  end

  // Drive words with a ready pulse; returns just after the capturing edge.
  task automatic capture(input string rs, input string qs, input logic acc);
    @(negedge clk);
    R = enc(rs);
    Q = enc(qs);
    aln_ready = 1'b1;
    out_ready = acc;
    @(posedge clk);
    expA = model(enc(rs), enc(qs), 8);
    expB = model(enc(rs), enc(qs), 4);
  endtask

  // Latency from the capture edge to out_valid must be exactly NSYM edges.
  task automatic wait_valid(input string nm);
    int j;
    j = 0;
    @(negedge clk);
    aln_ready = 1'b0;
    out_ready = 1'b0;
    while (!vA && j < 30) begin
      @(negedge clk);
      j++;
    end
    chk({nm, "_latency"}, j, 10);
  endtask

  task automatic lit(input string nm, input int m, input int mm, input int g,
                     input int sa, input int sb, input int inv);
    chk({nm, "_match"}, int'(mA), m);
    chk({nm, "_mism"},  int'(mmA), mm);
    chk({nm, "_gap"},   int'(gA), g);
    chk({nm, "_scoreA"}, int'(sA), sa);
    chk({nm, "_scoreB"}, int'(sB), sb);
    chk({nm, "_inv"},   int'(iA), inv);
  endtask

  task automatic accept(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, int'(vA), 0);
    chk({nm, "_idle"}, int'(bA), 0);
  endtask

  initial begin
    reset     = 1'b1;
    aln_ready = 1'b0;
    out_ready = 1'b0;
    R         = '0;
    Q         = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(vA), 0);
    chk("rst_busy",  int'(bA), 0);
    chk("rst_ovf",   int'(oA), 0);
    chk("rst_score", int'(sA), 0);
    chk("rst_match", int'(mA), 0);
    reset = 1'b0;

    // All match: B saturates at +7
    capture("ACGTACGTAC", "ACGTACGTAC", 1'b0);
    wait_valid("t1");
    lit("t1", 10, 0, 0, 20, 7, 0);
    accept("t1");

    // Gaps and mismatches
    capture("AC-GTACGTA", "ACGGT-CGAT", 1'b0);
    wait_valid("t2");
    lit("t2", 6, 2, 2, 6, 5, 0);
    accept("t2");

    // Trailing pad is ignored
    capture("ACGT......", "AGGT......", 1'b0);
    wait_valid("t3");
    lit("t3", 3, 1, 0, 5, 5, 0);
    accept("t3");

    // Pad against base
    capture("..........", "A.........", 1'b0);
    wait_valid("t3b");
    lit("t3b", 0, 0, 0, 0, 0, 1);
    accept("t3b");

    // Illegal code and gap/gap flag invalid but counting continues
    capture("AxGT-.....", "AACT-.....", 1'b0);
    wait_valid("t3c");
    lit("t3c", 2, 1, 0, 3, 3, 1);

    // New rise on the accepting edge goes straight to SCAN, no overflow
    capture("AAAAAAAAAA", "CCCCCCCCCC", 1'b1);
    wait_valid("t6");
    lit("t6", 0, 10, 0, -10, -8, 0);
    chk("t6_no_ovf", int'(oA), 0);
    accept("t6");

    // Hold the record; a rise in DONE is dropped and flagged
    capture("AC-GTACGTA", "ACGGT-CGAT", 1'b0);
    wait_valid("t4");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      aln_ready = (i == 5);
      if (i == 5) R = enc("TTTTTTTTTT");
      chk("t4_hold_busy", int'(bA), 1);
      chk("t4_hold_valid", int'(vA), 1);
      if (i == 5) begin
        @(posedge clk);
        exp_ovf = 1;
      end
    end
    chk("t4_ovf", int'(oA), 1);
    lit("t4", 6, 2, 2, 6, 5, 0);
    accept("t4");

    // Asynchronous reset in the middle of a scan (idx = 4)
    capture("ACGTACGTAC", "ACGTACGTAC", 1'b0);
    @(negedge clk);
    aln_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t5_busy_pre", int'(bA), 1);
    reset = 1'b1;
    exp_ovf = 0;
    #1;
    chk("t5_busy",  int'(bA), 0);
    chk("t5_ovf",   int'(oA), 0);
    chk("t5_valid", int'(vA), 0);
    chk("t5_match", int'(mA), 0);
    chk("t5_score", int'(sA), 0);
    @(negedge clk);
    reset = 1'b0;
    capture("ACGT......", "AGGT......", 1'b0);
    wait_valid("t5f");
    lit("t5f", 3, 1, 0, 5, 5, 0);
    accept("t5f");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
